// File: rtl/ddr5_cmd_responder_pkg.sv
// ddr5_cmd_responder_pkg: shared types and constants for the DDR5 command responder.
//   Holds the command encoding, address field widths, response error codes,
//   the per-bank state record, the decoder state enum and the latency/timing constants.
package ddr5_cmd_responder_pkg;

    typedef enum logic [2:0] {
        CMD_ACT0 = 3'd0,
        CMD_ACT1 = 3'd1,
        CMD_RD0  = 3'd2,
        CMD_RD1  = 3'd3,
        CMD_WR0  = 3'd4,
        CMD_WR1  = 3'd5,
        CMD_PRE  = 3'd6,
        CMD_REF  = 3'd7
    } ddr5_cmd_t;

    localparam int ROW_W      = 16;
    localparam int COL_W      = 10;
    localparam int BG_W       = 3;
    localparam int BANK_W     = 2;
    localparam int ADDR_W     = ROW_W + COL_W + BG_W + BANK_W;
    localparam int NUM_BG     = 8;
    localparam int NUM_BANK   = 4;
    localparam int NUM_BANKS  = NUM_BG * NUM_BANK;

    localparam int T_CL  = 40;
    localparam int T_CWL = 38;
    localparam int T_RCD = 39;
    localparam int T_RP  = 39;
    localparam int T_RAS = 76;

    typedef enum logic [2:0] {
        ERR_NONE     = 3'd0,
        ERR_SEQ      = 3'd1,
        ERR_CLOSED   = 3'd2,
        ERR_ROW_MISS = 3'd3,
        ERR_ACT_OPEN = 3'd4,
        ERR_REF_OPEN = 3'd5,
        ERR_TRCD     = 3'd6,
        ERR_TRP_TRAS = 3'd7
    } resp_err_t;

    typedef struct packed {
        logic             open;
        logic [ROW_W-1:0] row;
    } bank_state_t;

    typedef enum logic {
        EXP_FIRST  = 1'b0,
        EXP_SECOND = 1'b1
    } dec_state_t;

    function automatic logic [ADDR_W-1:0] pack_addr(
        input logic [ROW_W-1:0]  row,
        input logic [COL_W-1:0]  col,
        input logic [BG_W-1:0]   bg,
        input logic [BANK_W-1:0] bank
    );
        return {row, col, bg, bank};
    endfunction

endpackage

// File: rtl/ddr5_cmd_responder_delay_line.sv
// ddr5_resp_delay_line: fixed-latency valid+payload shift pipe with synchronous clear.
//   i_clock   in  1     clock
//   i_reset_n in  1     synchronous active-low clear of every stage
//   i_valid   in  1     token present this cycle
//   i_data    in  W     token payload
//   o_valid   out 1     token emerges DEPTH cycles after the edge that sampled i_valid
//   o_data    out W     payload of the emerging token, zero when no token
module ddr5_resp_delay_line
    import ddr5_cmd_responder_pkg::*;
#(
    parameter int DEPTH = T_CL,
    parameter int W     = ADDR_W
) (
    input  logic         i_clock,
    input  logic         i_reset_n,
    input  logic         i_valid,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    output logic [W-1:0] o_data
);

    // DEPTH+1 stages: the capture edge itself is stage 0, so stage DEPTH is DEPTH edges later.
    logic [DEPTH:0] r_valid;
    logic [W-1:0]   r_data [DEPTH+1];

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_valid <= '0;
            for (int i = 0; i <= DEPTH; i++) r_data[i] <= '0;
        end else begin
            r_valid   <= {r_valid[DEPTH-1:0], i_valid};
            r_data[0] <= i_valid ? i_data : '0;
            for (int i = 1; i <= DEPTH; i++) r_data[i] <= r_data[i-1];
        end
    end

    assign o_valid = r_valid[DEPTH];
    assign o_data  = r_data[DEPTH];

endmodule

// File: rtl/ddr5_cmd_responder.sv
// ddr5_cmd_responder: DIMM-side DDR5 command decoder, bank tracker and CL/CWL return generator.
//   i_clock      in  1   clock
//   i_reset_n    in  1   synchronous active-low reset
//   i_cmd_valid  in  1   command half present
//   i_cmd        in  3   ddr5_cmd_t
//   i_cmd_bg     in  3   bank group
//   i_cmd_bank   in  2   bank
//   i_cmd_row    in  16  row, latched with the first half
//   i_cmd_col    in  10  column, latched with the first half
//   o_rd_valid   out 1   read return pulse, T_CL after RD1
//   o_rd_addr    out 31  {row,col,bg,bank} of the read
//   o_wr_ack     out 1   write ack pulse, T_CWL after WR1
//   o_wr_addr    out 31  {row,col,bg,bank} of the write
//   o_err_valid  out 1   registered error pulse
//   o_err_code   out 3   resp_err_t
//   o_bank_open  out 32  bit bg*4+bank set while that bank is active
// Build option: DDR5_RESP_TIMING_CHECK_EN adds tRCD/tRP/tRAS checking (report-only).
module ddr5_cmd_responder
    import ddr5_cmd_responder_pkg::*;
(
    input  logic        i_clock,
    input  logic        i_reset_n,
    input  logic        i_cmd_valid,
    input  logic [2:0]  i_cmd,
    input  logic [2:0]  i_cmd_bg,
    input  logic [1:0]  i_cmd_bank,
    input  logic [15:0] i_cmd_row,
    input  logic [9:0]  i_cmd_col,
    output logic        o_rd_valid,
    output logic [30:0] o_rd_addr,
    output logic        o_wr_ack,
    output logic [30:0] o_wr_addr,
    output logic        o_err_valid,
    output logic [2:0]  o_err_code,
    output logic [31:0] o_bank_open
);

    dec_state_t        r_state;
    ddr5_cmd_t         r_cmd;
    logic [BG_W-1:0]   r_bg;
    logic [BANK_W-1:0] r_bank;
    logic [ROW_W-1:0]  r_row;
    logic [COL_W-1:0]  r_col;
    bank_state_t       r_banks [NUM_BANKS];
    logic              r_err_valid;
    resp_err_t         r_err_code;

    ddr5_cmd_t         w_cmd;
    logic              w_pair_ok;
    logic              w_first_half;
    logic              w_seq_err;
    logic              w_exec_pair;
    logic              w_exec_pre;
    logic              w_exec_ref;
    logic              w_is_act;
    logic              w_is_rd;
    logic              w_is_wr;
    logic              w_is_acc;
    logic              w_act_ok;
    logic              w_acc_ok;
    logic              w_pre_close;
    logic              w_rd_push;
    logic              w_wr_push;
    logic [4:0]        w_idx;
    bank_state_t       w_bank;
    logic [31:0]       w_open_vec;
    resp_err_t         w_t_err;
    resp_err_t         w_err;
    logic [ADDR_W-1:0] w_addr;

`ifdef DDR5_RESP_TIMING_CHECK_EN
    // Cycles elapsed since the last ACT1 / closing PRE per bank; saturate so idle banks never flag.
    logic [7:0] r_since_act [NUM_BANKS];
    logic [7:0] r_since_pre [NUM_BANKS];
`endif

    always_comb begin
        w_cmd        = ddr5_cmd_t'(i_cmd);
        // Second halves are encoded as first half + 1.
        w_pair_ok    = i_cmd_valid && w_cmd == ddr5_cmd_t'(r_cmd + 3'd1)
                       && i_cmd_bg == r_bg && i_cmd_bank == r_bank;
        w_first_half = r_state == EXP_FIRST && i_cmd_valid && (w_cmd inside {CMD_ACT0, CMD_RD0, CMD_WR0});
        w_seq_err    = (r_state == EXP_SECOND && !w_pair_ok)
                       || (r_state == EXP_FIRST && i_cmd_valid && (w_cmd inside {CMD_ACT1, CMD_RD1, CMD_WR1}));
        w_exec_pair  = r_state == EXP_SECOND && w_pair_ok;
        w_exec_pre   = r_state == EXP_FIRST && i_cmd_valid && w_cmd == CMD_PRE;
        w_exec_ref   = r_state == EXP_FIRST && i_cmd_valid && w_cmd == CMD_REF;
        w_idx        = w_exec_pair ? {r_bg, r_bank} : {i_cmd_bg, i_cmd_bank};
        w_bank       = r_banks[w_idx];
        for (int b = 0; b < NUM_BANKS; b++) w_open_vec[b] = r_banks[b].open;
        w_is_act     = w_exec_pair && r_cmd == CMD_ACT0;
        w_is_rd      = w_exec_pair && r_cmd == CMD_RD0;
        w_is_wr      = w_exec_pair && r_cmd == CMD_WR0;
        w_is_acc     = w_is_rd || w_is_wr;
        w_act_ok     = w_is_act && !w_bank.open;
        w_acc_ok     = w_is_acc && w_bank.open && w_bank.row == r_row;
        w_pre_close  = w_exec_pre && w_bank.open;
        w_rd_push    = w_acc_ok && w_is_rd;
        w_wr_push    = w_acc_ok && w_is_wr;
`ifdef DDR5_RESP_TIMING_CHECK_EN
        w_t_err      = (w_acc_ok && r_since_act[w_idx] < 8'(T_RCD)) ? ERR_TRCD
                     : ((w_act_ok && r_since_pre[w_idx] < 8'(T_RP))
                        || (w_pre_close && r_since_act[w_idx] < 8'(T_RAS))) ? ERR_TRP_TRAS
                     : ERR_NONE;
`else
        w_t_err      = ERR_NONE;
`endif
        w_err        = w_seq_err                           ? ERR_SEQ
                     : (w_is_act && w_bank.open)           ? ERR_ACT_OPEN
                     : (w_is_acc && !w_bank.open)          ? ERR_CLOSED
                     : (w_is_acc && w_bank.row != r_row)   ? ERR_ROW_MISS
                     : (w_exec_ref && |w_open_vec)         ? ERR_REF_OPEN
                     : w_t_err;
        w_addr       = pack_addr(r_row, r_col, r_bg, r_bank);
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_state     <= EXP_FIRST;
            r_cmd       <= CMD_ACT0;
            r_bg        <= '0;
            r_bank      <= '0;
            r_row       <= '0;
            r_col       <= '0;
            r_err_valid <= 1'b0;
            r_err_code  <= ERR_NONE;
            for (int b = 0; b < NUM_BANKS; b++) r_banks[b] <= '0;
        end else begin
            r_state     <= w_first_half ? EXP_SECOND : EXP_FIRST;
            r_err_valid <= w_err != ERR_NONE;
            r_err_code  <= w_err;
            // Row is latched on every first half so RD/WR can be checked against the open row.
            if (w_first_half) begin
                r_cmd  <= w_cmd;
                r_bg   <= i_cmd_bg;
                r_bank <= i_cmd_bank;
                r_row  <= i_cmd_row;
                r_col  <= i_cmd_col;
            end
            if (w_act_ok) r_banks[w_idx] <= '{open: 1'b1, row: r_row};
            if (w_pre_close) r_banks[w_idx].open <= 1'b0;
        end
    end

`ifdef DDR5_RESP_TIMING_CHECK_EN
    // Loading 1 at the command edge makes the counter equal the cycle distance at a later edge.
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                r_since_act[b] <= 8'hFF;
                r_since_pre[b] <= 8'hFF;
            end
        end else begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                r_since_act[b] <= (w_act_ok && w_idx == 5'(b)) ? 8'd1
                                : r_since_act[b] + {7'd0, ~&r_since_act[b]};
                r_since_pre[b] <= (w_pre_close && w_idx == 5'(b)) ? 8'd1
                                : r_since_pre[b] + {7'd0, ~&r_since_pre[b]};
            end
        end
    end
`endif

    ddr5_resp_delay_line #(.DEPTH(T_CL), .W(ADDR_W)) u_rd_line (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .i_valid   (w_rd_push),
        .i_data    (w_addr),
        .o_valid   (o_rd_valid),
        .o_data    (o_rd_addr)
    );

    ddr5_resp_delay_line #(.DEPTH(T_CWL), .W(ADDR_W)) u_wr_line (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .i_valid   (w_wr_push),
        .i_data    (w_addr),
        .o_valid   (o_wr_ack),
        .o_data    (o_wr_addr)
    );

    assign o_err_valid = r_err_valid;
    assign o_err_code  = r_err_code;
    assign o_bank_open = w_open_vec;

endmodule
